// File: rtl/hdmi_line_fetch_ctrl_pkg.sv
// Shared types and constants for the HDMI line fetch path.
package hdmi_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} fetch_state_t;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int BYTES_PER_PIX = 4;

    // Line to prefetch while y is displayed; past the last active line it wraps to 0.
    function automatic logic [10:0] next_line(input logic [10:0] y, input logic [11:0] v_active);
        logic [11:0] w_y1;
        w_y1 = {1'b0, y} + 12'd1;
        return (w_y1 >= v_active) ? 11'd0 : w_y1[10:0];
    endfunction

endpackage

// File: rtl/hdmi_line_fetch_ctrl.sv
// Avalon-MM burst read master that fetches the next active line into a ping-pong line buffer.
// state | meaning
// IDLE  | waiting for a line change (or a pending one)
// REQ   | avm_read held with a stable address until accepted
// DATA  | draining one burst into the line buffer
// DONE  | one-cycle line wrap-up before IDLE
module hdmi_line_fetch_ctrl
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BURST    = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [10:0]       hdmi_y,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [6:0]        avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              lb_wr_en,
    output logic              lb_wr_bank,
    output logic [10:0]       lb_wr_addr,
    output logic [31:0]       lb_wr_data,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr
);

    if (H_ACTIVE % BURST != 0) begin : g_chk_h_active
        $error("H_ACTIVE must be a multiple of BURST");
    end
    if (BURST < 1 || BURST > 64) begin : g_chk_burst
        $error("BURST must be in 1..64");
    end

    localparam logic [ADDR_W-1:0] LINE_BYTES  = ADDR_W'(H_ACTIVE * BYTES_PER_PIX);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST * BYTES_PER_PIX);
    localparam logic [10:0]       LAST_WORD   = 11'(H_ACTIVE - 1);
    localparam logic [6:0]        LAST_BEAT   = 7'(BURST - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [10:0]       r_y_prev;
    logic [10:0]       r_pend_target;
    logic              r_pend;
    logic              r_abort;
    logic              r_underrun;
    logic              r_bank;
    logic [ADDR_W-1:0] r_addr;
    logic [10:0]       r_word_cnt;
    logic [6:0]        r_beat_cnt;

    logic              w_trig;
    logic              w_busy_trig;
    logic [10:0]       w_target;
    logic [10:0]       w_start_target;
    logic              w_start;
    logic              w_beat;
    logic              w_last_beat;

    assign w_trig         = (hdmi_y != r_y_prev) && enable;
    assign w_busy_trig    = w_trig && (r_state == REQ || r_state == DATA);
    assign w_target       = next_line(hdmi_y, 12'(V_ACTIVE));
    assign w_start_target = w_trig ? w_target : r_pend_target;
    assign w_beat         = (r_state == DATA) && avm_readdatavalid;
    assign w_last_beat    = w_beat && (r_beat_cnt == LAST_BEAT);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trig || (r_pend && enable)) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                // A burst in flight always drains; stopping is only decided at its last beat.
                if (w_last_beat) begin
                    if (r_word_cnt == LAST_WORD || r_abort || w_busy_trig || !enable) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_y_prev      <= 11'h7FF;
            r_pend_target <= '0;
            r_pend        <= 1'b0;
            r_abort       <= 1'b0;
            r_underrun    <= 1'b0;
            r_bank        <= 1'b0;
            r_addr        <= '0;
            r_word_cnt    <= '0;
            r_beat_cnt    <= '0;
        end else begin
            r_y_prev <= hdmi_y;

            if (w_busy_trig) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end

            if (r_state == IDLE) begin
                r_abort <= 1'b0;
            end

            if (w_start) begin
                r_bank     <= w_start_target[0];
                r_addr     <= fb_base + ADDR_W'(w_start_target) * LINE_BYTES;
                r_word_cnt <= '0;
                r_pend     <= 1'b0;
            end

            if (r_state == REQ && !avm_waitrequest) begin
                r_beat_cnt <= '0;
            end

            if (w_beat) begin
                r_word_cnt <= r_word_cnt + 11'd1;
                r_beat_cnt <= r_beat_cnt + 7'd1;
            end

            if (w_last_beat) begin
                r_addr <= r_addr + BURST_BYTES;
            end

            // Only the newest line change survives; a change during DONE is just queued.
            if (w_busy_trig) begin
                r_abort <= 1'b1;
            end
            if (w_busy_trig || (w_trig && r_state == DONE)) begin
                r_pend        <= 1'b1;
                r_pend_target <= w_target;
            end
        end
    end

    assign avm_read       = (r_state == REQ);
    assign avm_address    = r_addr;
    assign avm_burstcount = (r_state == REQ) ? 7'(BURST) : 7'd0;
    assign lb_wr_en       = w_beat;
    assign lb_wr_bank     = r_bank;
    assign lb_wr_addr     = r_word_cnt;
    assign lb_wr_data     = w_beat ? avm_readdata : 32'd0;
    assign busy           = (r_state != IDLE);
    assign underrun       = r_underrun;

endmodule
